// File: rtl/sqrt2_pkg.sv
// rtl/sqrt2_pkg.sv - binary16 field widths, special encodings and FSM states for sqrt2_unit
package sqrt2_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;
  localparam int ROOT_W = FRAC_W + 1;
  localparam int RAD_W  = 2 * ROOT_W;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;
  localparam logic [15:0] NINF = 16'hFC00;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ITER,
    DONE
  } state_e;

endpackage

// File: rtl/sqrt2_iter.sv
// rtl/sqrt2_iter.sv - restoring integer square root, one root bit per clock
module sqrt2_iter
  import sqrt2_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [RAD_W-1:0]  radicand_i,
  output logic              last_o,
  output logic [FRAC_W-1:0] frac_o
);

  logic [RAD_W-1:0]  rad_q;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [11:0]       rem_q, rem_d;
  logic [3:0]        cnt_q;
  logic              busy_q;
  logic [13:0]       rem_sh, trial;
  logic              ge;

  // Remainder never exceeds 2*root, so 12 bits hold it between steps
  always_comb begin
    rem_sh = {rem_q, rad_q[RAD_W-1 -: 2]};
    trial  = {1'b0, root_q, 2'b01};
    ge     = (rem_sh >= trial);
    rem_d  = ge ? 12'(rem_sh - trial) : rem_sh[11:0];
    root_d = {root_q[ROOT_W-2:0], ge};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rad_q  <= radicand_i;
      root_q <= '0;
      rem_q  <= '0;
      cnt_q  <= 4'(ROOT_W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rad_q  <= {rad_q[RAD_W-3:0], 2'b00};
      root_q <= root_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) busy_q <= 1'b0;
    end
  end

  assign last_o = busy_q && (cnt_q == 4'd1);
  assign frac_o = root_q[FRAC_W-1:0];

endmodule

// File: rtl/sqrt2_unit.sv
// rtl/sqrt2_unit.sv - binary16 square-root peripheral with shared tri-state data bus
module sqrt2_unit
  import sqrt2_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  inout  wire [15:0] IO_DATA,
  output logic       RESULT,
  output logic       IS_NAN,
  output logic       IS_PINF,
  output logic       IS_NINF
);

  state_e             state_q;
  logic [15:0]        op_q, res_q;
  logic [EXP_W-1:0]   exp_q;
  logic               norm_path_q, result_q;
  logic [2:0]         pend_q, flags_q;

  logic [EXP_W-1:0]   op_exp;
  logic [FRAC_W-1:0]  op_frac;
  logic               special;
  logic [15:0]        spec_res;
  logic [2:0]         spec_flags;
  logic [3:0]         lead;
  logic [ROOT_W-1:0]  m11;
  logic [ROOT_W:0]    m12;
  logic signed [6:0]  e_s, e_ev;
  logic [EXP_W-1:0]   exp_r;
  logic [RAD_W-1:0]   rad;
  logic               start, iter_last;
  logic [FRAC_W-1:0]  root_frac;

  assign op_exp  = op_q[FRAC_W +: EXP_W];
  assign op_frac = op_q[FRAC_W-1:0];

  // Flag order is {nan, pinf, ninf}
  always_comb begin
    special    = 1'b1;
    spec_res   = QNAN;
    spec_flags = 3'b000;
    if (op_q == NINF) begin
      spec_flags = 3'b101;
    end else if (op_exp == '1 && op_frac != '0) begin
      spec_flags = 3'b100;
    end else if (op_q == PINF) begin
      spec_res   = PINF;
      spec_flags = 3'b010;
    end else if (op_q[14:0] == '0) begin
      spec_res   = op_q;
    end else if (op_q[15]) begin
      spec_flags = 3'b100;
    end else begin
      special    = 1'b0;
    end
  end

  // Subnormals shift their leading one up to the hidden-bit position
  always_comb begin
    lead = '0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (op_frac[i]) lead = 4'(i);
    end
    if (op_exp != '0) begin
      m11 = {1'b1, op_frac};
      e_s = 7'({2'b00, op_exp}) - 7'(BIAS);
    end else begin
      m11 = 11'({1'b0, op_frac} << (4'd10 - lead));
      e_s = 7'({3'b000, lead}) - 7'd24;
    end
    m12   = e_s[0] ? {m11, 1'b0} : {1'b0, m11};
    e_ev  = e_s - {6'b0, e_s[0]};
    exp_r = 5'((e_ev >>> 1) + 7'sd15);
    rad   = {m12, {FRAC_W{1'b0}}};
  end

  assign start = (state_q == NORM) && ENABLE && !special;

  sqrt2_iter u_iter (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .start_i    (start),
    .radicand_i (rad),
    .last_o     (iter_last),
    .frac_o     (root_frac)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      op_q        <= '0;
      res_q       <= '0;
      exp_q       <= '0;
      norm_path_q <= 1'b0;
      result_q    <= 1'b0;
      pend_q      <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ENABLE) begin
            op_q    <= IO_DATA;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (!ENABLE) begin
            state_q <= IDLE;
          end else if (special) begin
            res_q       <= spec_res;
            pend_q      <= spec_flags;
            norm_path_q <= 1'b0;
            state_q     <= DONE;
          end else begin
            exp_q       <= exp_r;
            pend_q      <= '0;
            norm_path_q <= 1'b1;
            state_q     <= ITER;
          end
        end
        ITER: begin
          if (!ENABLE)        state_q <= IDLE;
          else if (iter_last) state_q <= DONE;
        end
        DONE: begin
          if (!ENABLE) begin
            state_q  <= IDLE;
            result_q <= 1'b0;
            flags_q  <= '0;
          end else if (!result_q) begin
            result_q <= 1'b1;
            flags_q  <= pend_q;
            if (norm_path_q) res_q <= {1'b0, exp_q, root_frac};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IO_DATA = (result_q && ENABLE) ? res_q : 16'bz;
  assign RESULT  = result_q;
  assign IS_NAN  = flags_q[2];
  assign IS_PINF = flags_q[1];
  assign IS_NINF = flags_q[0];

endmodule

// File: tb/tb_sqrt2_unit.sv
// tb/tb_sqrt2_unit.sv - directed scoreboard bench for sqrt2_unit
module tb_sqrt2_unit;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE;
  logic        host_en;
  logic [15:0] host_drv;
  wire  [15:0] io_data;
  logic        RESULT, IS_NAN, IS_PINF, IS_NINF;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  assign io_data = host_en ? host_drv : 16'bz;

  always #5 CLK = ~CLK;

  sqrt2_unit dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENABLE  (ENABLE),
    .IO_DATA (io_data),
    .RESULT  (RESULT),
    .IS_NAN  (IS_NAN),
    .IS_PINF (IS_PINF),
    .IS_NINF (IS_NINF)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // A released bus reads back whatever the host drives, in both polarities
  task automatic check_bus_free(input string tag);
    host_drv = 16'h0000;
    host_en  = 1'b1;
    #1 check({tag, "_bus0"}, io_data, 32'h0000);
    host_drv = 16'hFFFF;
    #1 check({tag, "_bus1"}, io_data, 32'hFFFF);
    host_en  = 1'b0;
  endtask

  task automatic start_op(input logic [15:0] op, input logic [15:0] res,
                          input logic [2:0] flags, input int lat);
    exp_t e;
    e.data = res; e.flags = flags; e.lat = lat;
    sb.push_back(e);
    @(negedge CLK);
    host_drv = op;
    host_en  = 1'b1;
    ENABLE   = 1'b1;
    @(negedge CLK);
    host_en  = 1'b0;
  endtask

  task automatic finish_op(input string tag);
    exp_t e;
    int   k = 0;
    while (!RESULT && k < 40) begin
      @(negedge CLK);
      k++;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, k, e.lat);
    check({tag, "_data"}, io_data, {16'h0, e.data});
    check({tag, "_flags"}, {IS_NAN, IS_PINF, IS_NINF}, {29'h0, e.flags});
    ENABLE = 1'b0;
    @(negedge CLK);
    check({tag, "_rel_result"}, RESULT, 0);
    check({tag, "_rel_flags"}, {IS_NAN, IS_PINF, IS_NINF}, 0);
    check_bus_free(tag);
  endtask

  logic [15:0] ops  [11] = '{16'h3C00, 16'h4400, 16'h3400, 16'h2392, 16'h7C00, 16'hFC00,
                             16'hBC00, 16'h7E01, 16'h8000, 16'h0001, 16'h0004};
  logic [15:0] ress [11] = '{16'h3C00, 16'h4000, 16'h3800, 16'h2FC8, 16'h7C00, 16'h7E00,
                             16'h7E00, 16'h7E00, 16'h8000, 16'h0C00, 16'h1000};
  logic [2:0]  flgs [11] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b101,
                             3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
  int          lats [11] = '{13, 13, 13, 13, 2, 2, 2, 2, 2, 13, 13};

  initial begin
    logic seen;
    RESET    = 1'b1;
    ENABLE   = 1'b0;
    host_en  = 1'b0;
    host_drv = '0;
    repeat (3) @(negedge CLK);
    check("reset_result", RESULT, 0);
    check("reset_flags", {IS_NAN, IS_PINF, IS_NINF}, 0);
    RESET = 1'b0;
    check_bus_free("reset");

    for (int i = 0; i < 11; i++) begin
      start_op(ops[i], ress[i], flgs[i], lats[i]);
      finish_op($sformatf("op_%04h", ops[i]));
    end

    // Abort mid-iteration: nothing may appear, then a fresh operation works
    @(negedge CLK);
    host_drv = 16'h4400; host_en = 1'b1; ENABLE = 1'b1;
    @(negedge CLK);
    host_en = 1'b0;
    repeat (4) @(negedge CLK);
    ENABLE = 1'b0;
    seen = 1'b0;
    repeat (16) begin
      @(negedge CLK);
      if (RESULT) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    check_bus_free("abort");
    start_op(16'h4400, 16'h4000, 3'b000, 13);
    finish_op("after_abort");

    // Reset mid-iteration with ENABLE held: the new operand must be the one computed
    @(negedge CLK);
    host_drv = 16'h4400; host_en = 1'b1; ENABLE = 1'b1;
    @(negedge CLK);
    host_en = 1'b0;
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    host_drv = 16'h3400; host_en = 1'b1;
    @(negedge CLK);
    check("reset_iter_result", RESULT, 0);
    RESET = 1'b0;
    begin
      exp_t e;
      e.data = 16'h3800; e.flags = 3'b000; e.lat = 13;
      sb.push_back(e);
    end
    @(negedge CLK);
    host_en = 1'b0;
    finish_op("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
